branch_res_arbiter: RTL and testbench
=====================================

// Module: branch_res_arbiter
// PURPOSE
// - Shares the single frontend resolution port (BPU update + PC-gen redirect) among N_REQ branch-unit
//   resolution sources, enabling multiple branch units in the execution pipeline.
// - Mispredictions are served oldest-first by ROB age; correct predictions are served round-robin.
// - Holds the issue-stage stall until the pipeline flush completes.
// PARAMETERS
// - N_REQ    2   number of resolution requesters (>=2)
// - RR_INIT  0   round-robin pointer value after reset/flush
// PORTS
// - clk_i             in   1                    clock
// - rst_ni            in   1                    reset, asynchronous, active-low
// - flush_i           in   1                    pipeline flush (synchronous clear)
// - rob_head_idx_i    in   ROB_IDX_LEN          ROB head; reference point for age
// - req_valid_i       in   N_REQ                per-requester valid
// - req_ready_o       out  N_REQ                per-requester ready (one-hot or zero)
// - req_data_i        in   N_REQ x bu_res_req_t resolution_t + rob_idx per requester
// - fe_bpu_valid_o    out  1                    BPU update valid (BPU always accepts)
// - fe_pcgen_valid_o  out  1                    redirect valid, held until fe_pcgen_ready_i
// - fe_pcgen_ready_i  in   1                    PC-gen accepts redirect
// - fe_res_o          out  resolution_t         registered resolution to frontend
// - issue_mis_o       out  1                    stall issue: misprediction pending
// BEHAVIOUR
// - Reset: all outputs 0, fe_res_o='0, state IDLE, rr_ptr=RR_INIT, pend_rob_idx='0.
// - Age: age(i) = req rob_idx - rob_head_idx_i, modulo 2^ROB_IDX_LEN; smaller age means older.
// - At most one request is accepted per cycle (req_valid_i[i] & req_ready_o[i]).
// - Latency: fe_res_o and the output valids are registered, 1 cycle after acceptance.
// - FSM IDLE:
//   - A valid req with res.mispredict=1 exists: accept the one with the smallest age.
//     Register it, set pend_rob_idx, assert fe_bpu_valid_o (1 cycle), fe_pcgen_valid_o
//     and issue_mis_o. Go to MIS_SEND.
//   - Otherwise: accept the round-robin winner from rr_ptr. Pulse fe_bpu_valid_o for 1 cycle.
//     rr_ptr <= winner+1 mod N_REQ.
// - FSM MIS_SEND: fe_pcgen_valid_o and fe_res_o stay stable until fe_pcgen_ready_i.
//   - Older mispredict (age < pend age), with fe_pcgen_ready_i=0: accepted and replaces the
//     registered resolution. fe_bpu_valid_o pulses. Stays in MIS_SEND.
//   - With fe_pcgen_ready_i=1: no replacement; ready stays low for that requester.
//   - Non-mispredict older than pend: accepted, BPU pulse only, fe_res_o is not overwritten
//     while a redirect is pending; the BPU update is dropped. Younger requests are accepted and
//     discarded: no output, and no deadlock on the flushed path.
//   - On fe_pcgen_ready_i: fe_pcgen_valid_o <= 0. Go to MIS_WAIT.
// - FSM MIS_WAIT: issue_mis_o=1. Younger requests are accepted and discarded; older
//   non-mispredict requests are handled as in MIS_SEND. Leaves only on flush_i.
// - issue_mis_o: 1 in MIS_SEND/MIS_WAIT (registered with state entry), 0 in IDLE.
// - flush_i (any state, priority over everything including a same-cycle handshake):
//   - req_ready_o=0 that cycle.
//   - Next cycle: state IDLE, all valids and issue_mis_o 0, rr_ptr=RR_INIT.
//   - fe_res_o keeps its value (don't-care).
// - Reset mid-MIS_SEND: redirect is lost by design; the frontend is reset in the same event.
// - Age wrap: rob_idx < rob_head_idx_i is handled by the modular subtraction; no special case.
// - Equal rob_idx on two requesters is illegal; the bench asserts it never occurs.
// STRUCTURE
// - expipe_pkg: typedef bu_res_req_t {fetch_pkg::resolution_t res; rob_idx_t rob_idx;}.
// - expipe_pkg: function rob_age(rob_idx_t idx, rob_idx_t head).
// - expipe_pkg: enum bra_state_t {BRA_IDLE, BRA_MIS_SEND, BRA_MIS_WAIT}.
// - Sub-module: rr_arbiter #(N) for the round-robin pick (req vector + ptr -> one-hot grant).
// - Oldest-mispredict selection: linear age-compare tree, inline.
// TESTING
// - Reset, no reqs -> all outputs 0, req_ready_o=0 over 10 cycles.
// - req0 and req1 both correct (mispredict=0), held valid 4 cycles -> grants alternate
//   0,1,0,1; fe_bpu_valid_o pulses each cycle; issue_mis_o=0.
// - head=6, req0 mis rob=7, req1 mis rob=2 (wrapped, ROB depth 8) -> req0 granted (age 1
//   vs 4); fe_pcgen_valid_o next cycle with req0 pc/target; issue_mis_o=1.
// - MIS_SEND pending rob=5, head=3, fe_pcgen_ready_i=0; req1 mis rob=4 -> replaces;
//   fe_res_o.target updates; fe_pcgen_ready_i=1 -> MIS_WAIT, pcgen valid drops, issue_mis_o=1.
// - MIS_WAIT, younger req valid -> accepted, no fe valid pulses; flush_i -> IDLE next cycle,
//   issue_mis_o=0.
// - flush_i same cycle as fe_pcgen_ready_i in MIS_SEND -> IDLE next cycle, no MIS_WAIT
//   entry, req_ready_o=0 in the flush cycle.

Source files
------------

// File: rtl/branch_res_arbiter_pkg.sv
// Shared types for the branch-resolution arbiter: frontend resolution payload,
// per-requester request bundle, arbiter FSM states and the ROB age helper.
package branch_res_arbiter_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROB_IDX_LEN = 3;

    typedef logic [ROB_IDX_LEN-1:0] rob_idx_t;

    typedef struct packed {
        logic            mispredict;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    typedef struct packed {
        resolution_t res;
        rob_idx_t    rob_idx;
    } bu_res_req_t;

    typedef enum logic [1:0] {
        BRA_IDLE     = 2'd0,
        BRA_MIS_SEND = 2'd1,
        BRA_MIS_WAIT = 2'd2
    } bra_state_t;

    // Distance from the ROB head, wrapping naturally; smaller means older.
    function automatic rob_idx_t rob_age(rob_idx_t idx, rob_idx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/branch_res_arbiter_rr.sv
// Round-robin picker: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        int unsigned v_idx;
        logic        v_found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        v_found   = 1'b0;
        v_idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            v_idx = (32'(ptr_i) + k) % N;
            if (!v_found && req_i[v_idx]) begin
                v_found      = 1'b1;
                gnt_o[v_idx] = 1'b1;
                gnt_idx_o    = IW'(v_idx);
            end
        end
    end

endmodule

// File: rtl/branch_res_arbiter.sv
// Shares the frontend resolution port among N_REQ branch units: mispredicts
// oldest-first by ROB age, correct predictions round-robin, issue stalled until flush.
module branch_res_arbiter
    import branch_res_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned RR_INIT = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  rob_idx_t                 rob_head_idx_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  bu_res_req_t [N_REQ-1:0]  req_data_i,
    output logic                     fe_bpu_valid_o,
    output logic                     fe_pcgen_valid_o,
    input  logic                     fe_pcgen_ready_i,
    output resolution_t              fe_res_o,
    output logic                     issue_mis_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    bra_state_t  r_state;
    logic [IW-1:0] r_rr_ptr;
    rob_idx_t    r_pend_rob;
    resolution_t r_fe_res;
    logic        r_bpu_valid;
    logic        r_pcgen_valid;
    logic        r_issue_mis;

    rob_idx_t          w_pend_age;
    logic [N_REQ-1:0]  w_older;
    logic [N_REQ-1:0]  w_older_mis;
    logic              w_mis_found;
    logic [IW-1:0]     w_mis_idx;
    rob_idx_t          w_mis_age;
    logic              w_take_mis;
    logic [N_REQ-1:0]  w_rr_req;
    logic [N_REQ-1:0]  w_rr_gnt;
    logic [IW-1:0]     w_rr_idx;
    logic [IW-1:0]     w_rr_next;
    logic [IW-1:0]     w_sel_idx;
    logic              w_accept;
    logic [N_REQ-1:0]  w_ready;
    logic              w_sel_older;
    resolution_t       w_sel_res;

    // Linear age compare: oldest valid mispredict, plus which requesters are older than the pending one.
    always_comb begin
        rob_idx_t v_age;
        w_pend_age  = rob_age(r_pend_rob, rob_head_idx_i);
        w_older     = '0;
        w_older_mis = '0;
        w_mis_found = 1'b0;
        w_mis_idx   = '0;
        w_mis_age   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            v_age      = rob_age(req_data_i[i].rob_idx, rob_head_idx_i);
            w_older[i] = (v_age < w_pend_age);
            if (req_valid_i[i] && req_data_i[i].res.mispredict) begin
                w_older_mis[i] = w_older[i];
                if (!w_mis_found || (v_age < w_mis_age)) begin
                    w_mis_found = 1'b1;
                    w_mis_idx   = IW'(i);
                    w_mis_age   = v_age;
                end
            end
        end
    end

    // While a redirect is pending, older mispredicts are either taken as replacements or held off.
    always_comb begin
        w_take_mis = 1'b0;
        w_rr_req   = req_valid_i;
        case (r_state)
            BRA_IDLE: begin
                w_take_mis = w_mis_found;
            end
            BRA_MIS_SEND: begin
                w_take_mis = !fe_pcgen_ready_i && (|w_older_mis);
                w_rr_req   = req_valid_i & ~w_older_mis;
            end
            default: begin
                w_rr_req   = req_valid_i & ~w_older_mis;
            end
        endcase
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_i     (w_rr_req),
        .ptr_i     (r_rr_ptr),
        .gnt_o     (w_rr_gnt),
        .gnt_idx_o (w_rr_idx)
    );

    always_comb begin
        w_sel_idx = w_take_mis ? w_mis_idx : w_rr_idx;
        w_accept  = w_take_mis | (|w_rr_gnt);
        w_ready   = '0;
        if (w_accept && !flush_i) begin
            w_ready[w_sel_idx] = 1'b1;
        end
        w_sel_older = w_older[w_sel_idx];
        w_sel_res   = req_data_i[w_sel_idx].res;
        w_rr_next   = (w_rr_idx == IW'(N_REQ - 1)) ? '0 : w_rr_idx + IW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BRA_IDLE;
            r_rr_ptr      <= IW'(RR_INIT);
            r_pend_rob    <= '0;
            r_fe_res      <= '0;
            r_bpu_valid   <= 1'b0;
            r_pcgen_valid <= 1'b0;
            r_issue_mis   <= 1'b0;
        end else if (flush_i) begin
            r_state       <= BRA_IDLE;
            r_rr_ptr      <= IW'(RR_INIT);
            r_bpu_valid   <= 1'b0;
            r_pcgen_valid <= 1'b0;
            r_issue_mis   <= 1'b0;
        end else begin
            r_bpu_valid <= 1'b0;
            case (r_state)
                BRA_IDLE: begin
                    if (w_accept) begin
                        r_bpu_valid <= 1'b1;
                        r_fe_res    <= w_sel_res;
                        if (w_take_mis) begin
                            r_pend_rob    <= req_data_i[w_sel_idx].rob_idx;
                            r_pcgen_valid <= 1'b1;
                            r_issue_mis   <= 1'b1;
                            r_state       <= BRA_MIS_SEND;
                        end else begin
                            r_rr_ptr <= w_rr_next;
                        end
                    end
                end
                BRA_MIS_SEND: begin
                    if (w_take_mis) begin
                        r_bpu_valid <= 1'b1;
                        r_fe_res    <= w_sel_res;
                        r_pend_rob  <= req_data_i[w_sel_idx].rob_idx;
                    end else if (w_accept && w_sel_older) begin
                        r_bpu_valid <= 1'b1;
                    end
                    if (fe_pcgen_ready_i) begin
                        r_pcgen_valid <= 1'b0;
                        r_state       <= BRA_MIS_WAIT;
                    end
                end
                BRA_MIS_WAIT: begin
                    if (w_accept && w_sel_older) begin
                        r_bpu_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BRA_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o      = w_ready;
    assign fe_bpu_valid_o   = r_bpu_valid;
    assign fe_pcgen_valid_o = r_pcgen_valid;
    assign fe_res_o         = r_fe_res;
    assign issue_mis_o      = r_issue_mis;

endmodule

// File: tb/tb_branch_res_arbiter.sv
// Scoreboard bench for branch_res_arbiter: stimulus pushes expected frontend
// responses, a negedge monitor pops and compares on every BPU pulse.
module tb_branch_res_arbiter;
    import branch_res_arbiter_pkg::*;

    localparam int unsigned N = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 flush_i;
    rob_idx_t             rob_head_idx_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    bu_res_req_t [N-1:0]  req_data_i;
    logic                 fe_bpu_valid_o;
    logic                 fe_pcgen_valid_o;
    logic                 fe_pcgen_ready_i;
    resolution_t          fe_res_o;
    logic                 issue_mis_o;

    typedef struct packed {
        resolution_t res;
        logic        pcgen;
        logic        issue;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk_i = ~clk_i;

    branch_res_arbiter #(
        .N_REQ   (N),
        .RR_INIT (0)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .rob_head_idx_i   (rob_head_idx_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .fe_bpu_valid_o   (fe_bpu_valid_o),
        .fe_pcgen_valid_o (fe_pcgen_valid_o),
        .fe_pcgen_ready_i (fe_pcgen_ready_i),
        .fe_res_o         (fe_res_o),
        .issue_mis_o      (issue_mis_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic resolution_t mk(input logic mis, input logic [31:0] pc, input logic [31:0] tgt);
        resolution_t r;
        r.mispredict = mis;
        r.taken      = 1'b1;
        r.pc         = pc;
        r.target     = tgt;
        return r;
    endfunction

    function automatic exp_t ex(input resolution_t r, input logic pcgen, input logic issue);
        exp_t e;
        e.res   = r;
        e.pcgen = pcgen;
        e.issue = issue;
        return e;
    endfunction

    task automatic set_req(input int unsigned i, input logic v, input resolution_t r, input rob_idx_t rob);
        req_valid_i[i]         = v;
        req_data_i[i].res      = r;
        req_data_i[i].rob_idx  = rob;
    endtask

    // One cycle: check ready and held outputs at negedge, optionally push the expected pulse.
    task automatic cyc(input string name, input logic [N-1:0] exp_ready,
                       input logic exp_pcgen, input logic exp_issue,
                       input logic push, input exp_t e);
        @(negedge clk_i);
        check({name, "_ready"}, req_ready_o, exp_ready);
        check({name, "_pcgen_issue"}, {fe_pcgen_valid_o, issue_mis_o}, {exp_pcgen, exp_issue});
        if (push) sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && fe_bpu_valid_o) begin
            if (sb.size() == 0) begin
                check("bpu_unexpected", fe_bpu_valid_o, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("fe_res", fe_res_o, mon_e.res);
                check("pcgen_at_bpu", fe_pcgen_valid_o, mon_e.pcgen);
                check("issue_at_bpu", issue_mis_o, mon_e.issue);
            end
        end
    end

    always @(negedge clk_i) begin
        if (&req_valid_i) begin
            assert (req_data_i[0].rob_idx != req_data_i[1].rob_idx)
                else $error("two requesters share a rob_idx");
        end
    end

    resolution_t rA, rB, rC, rD, rE, rF, rG, rH, rI, rJ, rK, rL, rM;

    initial begin
        rA = mk(1'b0, 32'h100, 32'h200);
        rB = mk(1'b0, 32'h110, 32'h210);
        rC = mk(1'b1, 32'h300, 32'h380);
        rD = mk(1'b1, 32'h400, 32'h480);
        rE = mk(1'b1, 32'h500, 32'h510);
        rF = mk(1'b1, 32'h600, 32'h610);
        rG = mk(1'b0, 32'h700, 32'h710);
        rH = mk(1'b0, 32'h800, 32'h810);
        rI = mk(1'b1, 32'h900, 32'h910);
        rJ = mk(1'b0, 32'hA00, 32'hA10);
        rK = mk(1'b0, 32'hB00, 32'hB10);
        rL = mk(1'b1, 32'hC00, 32'hC10);
        rM = mk(1'b1, 32'hD00, 32'hD10);

        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        fe_pcgen_ready_i = 1'b0;
        rob_head_idx_i   = '0;
        req_valid_i      = '0;
        req_data_i       = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", req_ready_o, '0);
        check("rst_outs", {fe_bpu_valid_o, fe_pcgen_valid_o, issue_mis_o}, 3'b000);
        check("rst_res", fe_res_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) cyc("idle", 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check("idle_res", fe_res_o, '0);

        // Round-robin between two correct predictions
        set_req(0, 1'b1, rA, 3'd1);
        set_req(1, 1'b1, rB, 3'd2);
        cyc("rr0", 2'b01, 1'b0, 1'b0, 1'b1, ex(rA, 1'b0, 1'b0));
        cyc("rr1", 2'b10, 1'b0, 1'b0, 1'b1, ex(rB, 1'b0, 1'b0));
        cyc("rr2", 2'b01, 1'b0, 1'b0, 1'b1, ex(rA, 1'b0, 1'b0));
        cyc("rr3", 2'b10, 1'b0, 1'b0, 1'b1, ex(rB, 1'b0, 1'b0));
        req_valid_i = '0;
        cyc("rr_idle", 2'b00, 1'b0, 1'b0, 1'b0, '0);

        // Oldest mispredict with wrapped ROB index: age 1 beats age 4
        rob_head_idx_i = 3'd6;
        set_req(0, 1'b1, rC, 3'd7);
        set_req(1, 1'b1, rD, 3'd2);
        cyc("oldest", 2'b01, 1'b0, 1'b0, 1'b1, ex(rC, 1'b1, 1'b1));
        req_valid_i = '0;
        cyc("mis_hold0", 2'b00, 1'b1, 1'b1, 1'b0, '0);
        cyc("mis_hold1", 2'b00, 1'b1, 1'b1, 1'b0, '0);
        check("mis_hold_res", fe_res_o, rC);
        flush_i = 1'b1;
        set_req(0, 1'b1, rA, 3'd7);
        cyc("flush_a", 2'b00, 1'b1, 1'b1, 1'b0, '0);
        flush_i     = 1'b0;
        req_valid_i = '0;
        cyc("post_flush_a", 2'b00, 1'b0, 1'b0, 1'b0, '0);

        // Replacement by an older mispredict while the redirect is pending
        rob_head_idx_i = 3'd3;
        set_req(0, 1'b1, rE, 3'd5);
        cyc("mis_a", 2'b01, 1'b0, 1'b0, 1'b1, ex(rE, 1'b1, 1'b1));
        set_req(0, 1'b0, rE, 3'd5);
        set_req(1, 1'b1, rF, 3'd4);
        cyc("replace", 2'b10, 1'b1, 1'b1, 1'b1, ex(rF, 1'b1, 1'b1));
        set_req(1, 1'b0, rF, 3'd4);
        set_req(0, 1'b1, rG, 3'd7);
        cyc("younger_send", 2'b01, 1'b1, 1'b1, 1'b0, '0);
        set_req(0, 1'b1, rH, 3'd3);
        cyc("older_ok_send", 2'b01, 1'b1, 1'b1, 1'b1, ex(rF, 1'b1, 1'b1));
        set_req(0, 1'b1, rI, 3'd3);
        fe_pcgen_ready_i = 1'b1;
        cyc("ready_block", 2'b00, 1'b1, 1'b1, 1'b0, '0);
        fe_pcgen_ready_i = 1'b0;
        req_valid_i      = '0;
        cyc("mis_wait", 2'b00, 1'b0, 1'b1, 1'b0, '0);
        check("mis_wait_res", fe_res_o, rF);

        // MIS_WAIT: younger discarded, older correct pulses BPU only, then flush
        set_req(1, 1'b1, rJ, 3'd6);
        cyc("younger_wait", 2'b10, 1'b0, 1'b1, 1'b0, '0);
        set_req(1, 1'b1, rK, 3'd3);
        cyc("older_wait", 2'b10, 1'b0, 1'b1, 1'b1, ex(rF, 1'b0, 1'b1));
        flush_i = 1'b1;
        cyc("flush_b", 2'b00, 1'b0, 1'b1, 1'b0, '0);
        flush_i     = 1'b0;
        req_valid_i = '0;
        cyc("post_flush_b", 2'b00, 1'b0, 1'b0, 1'b0, '0);

        // Flush coincident with pcgen ready; pointer returns to RR_INIT
        rob_head_idx_i = 3'd0;
        set_req(0, 1'b1, rA, 3'd1);
        cyc("ptr_bump", 2'b01, 1'b0, 1'b0, 1'b1, ex(rA, 1'b0, 1'b0));
        set_req(0, 1'b1, rL, 3'd2);
        cyc("mis_c", 2'b01, 1'b0, 1'b0, 1'b1, ex(rL, 1'b1, 1'b1));
        set_req(0, 1'b0, rL, 3'd2);
        set_req(1, 1'b1, rM, 3'd1);
        flush_i          = 1'b1;
        fe_pcgen_ready_i = 1'b1;
        cyc("flush_c", 2'b00, 1'b1, 1'b1, 1'b0, '0);
        flush_i          = 1'b0;
        fe_pcgen_ready_i = 1'b0;
        req_valid_i      = '0;
        cyc("post_flush_c", 2'b00, 1'b0, 1'b0, 1'b0, '0);
        cyc("no_wait", 2'b00, 1'b0, 1'b0, 1'b0, '0);
        set_req(0, 1'b1, rA, 3'd1);
        set_req(1, 1'b1, rB, 3'd2);
        cyc("rr_reset", 2'b01, 1'b0, 1'b0, 1'b1, ex(rA, 1'b0, 1'b0));
        req_valid_i = '0;
        cyc("end", 2'b00, 1'b0, 1'b0, 1'b0, '0);

        repeat (2) @(posedge clk_i);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
